// File: rtl/keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner
//   Scans a 4x4 active-low key matrix. One column is driven low at a time
//   (rotation 1110 -> 1101 -> 1011 -> 0111). The rows are synchronised, sampled
//   in the last dwell cycle of each column, and folded into a per-scan result
//   (lowest key code wins). A debounce FSM, stepped once per full scan, accepts
//   presses and releases after DEBOUNCE_SCANS consistent scans.
//
// Parameters
//   SCAN_DIV        clk cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive scans needed to accept press/release (2..15)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   row_n  [3:0] matrix rows, pulled up, 0 = closed key on driven column (async)
//   col_n  [3:0] column drive, one-hot low
//   key_code[3:0] last accepted key, col*4 + row
//   key_valid    1-cycle pulse, new key accepted (key_code updated same cycle)
//   key_release  1-cycle pulse, accepted key released
//   key_held     high while the accepted key is down
// -----------------------------------------------------------------------------
module keypad_matrix_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_PEND,
    ST_PRESSED,
    ST_RELEASE_PEND
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchroniser (idle level is all-ones so reset looks like "no key")
  // ---------------------------------------------------------------------------
  logic [3:0] row_m;
  logic [3:0] row_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row_n;
      row_s <= row_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Column scan timing
  // ---------------------------------------------------------------------------
  logic [DW-1:0] dwell_q;
  logic [1:0]    col_q;
  logic          sample;
  logic          scan_end;

  assign sample   = (dwell_q == DW'(SCAN_DIV - 1));
  assign scan_end = sample && (col_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
      col_q   <= 2'd0;
      col_n   <= 4'b1110;
    end else if (sample) begin
      dwell_q <= '0;
      col_q   <= col_q + 2'd1;
      col_n   <= {col_n[2:0], col_n[3]};
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-scan accumulation: first hit in scan order is kept
  // ---------------------------------------------------------------------------
  logic       hit;
  logic [1:0] hit_row;
  logic       found_acc;
  logic [3:0] code_acc;
  logic       scan_found;
  logic [3:0] scan_code;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit_row = 2'd0;
    // Walk from the top so the lowest active row is the one left standing.
    for (int r = 3; r >= 0; r--) begin
      if (!row_s[r]) hit_row = 2'(r);
    end
  end

  assign hit        = (row_s != 4'hF);
  // The col3 sample is folded in directly since the result is used on that edge.
  assign scan_found = found_acc | hit;
  assign scan_code  = found_acc ? code_acc : {col_q, hit_row};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_acc <= 1'b0;
      code_acc  <= 4'd0;
    end else if (scan_end) begin
      found_acc <= 1'b0;
      code_acc  <= 4'd0;
    end else if (sample && !found_acc && hit) begin
      found_acc <= 1'b1;
      code_acc  <= {col_q, hit_row};
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: state register / next-state logic / output logic
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic       accept;
  logic       release_ev;
  logic [3:0] key_code_d;
  logic       key_held_d;
  logic       same_key;

  assign cnt_inc  = cnt_q + 4'd1;
  assign same_key = scan_found && (scan_code == cand_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RELEASED;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code    <= key_code_d;
      key_valid   <= accept;
      key_release <= release_ev;
      key_held    <= key_held_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    release_ev = 1'b0;
    if (scan_end) begin
      unique case (state_q)
        ST_RELEASED: begin
          if (scan_found) begin
            state_d = ST_PRESS_PEND;
            cand_d  = scan_code;
            cnt_d   = 4'd1;
          end
        end
        ST_PRESS_PEND: begin
          if (same_key) begin
            cnt_d = cnt_inc;
            if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
              state_d = ST_PRESSED;
              accept  = 1'b1;
            end
          end else if (scan_found) begin
            cand_d = scan_code;
            cnt_d  = 4'd1;
          end else begin
            state_d = ST_RELEASED;
          end
        end
        ST_PRESSED: begin
          if (!same_key) begin
            state_d = ST_RELEASE_PEND;
            cnt_d   = 4'd1;
          end
        end
        ST_RELEASE_PEND: begin
          if (same_key) begin
            state_d = ST_PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
              state_d    = ST_RELEASED;
              release_ev = 1'b1;
            end
          end
        end
        default: state_d = ST_RELEASED;
      endcase
    end
  end

  always_comb begin
    key_code_d = accept ? cand_q : key_code;
    key_held_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_PEND);
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_matrix_scanner
//   Models the physical key matrix around the scanner and predicts every output
//   from a scan-level reference: each scan's four column samples are collected,
//   reduced to (found, lowest code), and fed to a debounce model expressed as
//   "accepted key + run length of agreeing scans".
// -----------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

  localparam int SD  = 4;
  localparam int DEB = 3;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_held;

  logic [15:0] pressed = 16'h0000;

  int total = 0;
  int bad   = 0;
  int valid_cnt   = 0;
  int release_cnt = 0;

  keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_release (key_release),
    .key_held    (key_held)
  );

  always #5 clk = ~clk;

  // Physical matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_n[c] && pressed[c*4 + r]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         n;              // clock edges since reset release
  logic [3:0] hist [4];       // row_n seen just before edge k, stored at k%4
  logic [3:0] samp [4];       // per-column sample for the current scan
  bit         accepted, pending, losing;
  int         cand, streak;
  logic [3:0] e_code;
  bit         e_valid, e_release;

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      hist[i] = 4'hF;
      samp[i] = 4'hF;
    end
    accepted = 0; pending = 0; losing = 0;
    cand = 0; streak = 0;
    e_code = 4'd0; e_valid = 0; e_release = 0;
  endtask

  task automatic model_scan_end();
    bit found = 0;
    int code = 0;
    for (int k = 0; k < 16; k++)
      if (!found && !samp[k / 4][k % 4]) begin
        found = 1;
        code  = k;
      end
    if (!accepted) begin
      if (!pending) begin
        if (found) begin pending = 1; cand = code; streak = 1; end
      end else if (found && code == cand) begin
        streak++;
        if (streak == DEB) begin
          accepted = 1; pending = 0; e_code = 4'(cand); e_valid = 1;
        end
      end else if (found) begin
        cand = code; streak = 1;
      end else begin
        pending = 0;
      end
    end else begin
      if (found && code == cand) losing = 0;
      else if (!losing) begin losing = 1; streak = 1; end
      else begin
        streak++;
        if (streak == DEB) begin accepted = 0; losing = 0; e_release = 1; end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        n++;
        hist[n % 4] = row_n;
        e_valid = 0;
        e_release = 0;
        // The synchroniser delays rows two edges, so the sample taken at edge
        // n reflects the pins just before edge n-2.
        if (n % SD == 0) begin
          samp[((n / SD) - 1) % 4] = hist[(n - 2) % 4];
          if (n % SCAN == 0) model_scan_end();
        end
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    logic [3:0] ec;
    ec = 4'hF;
    ec[(n / SD) % 4] = 1'b0;
    check("col_n", 16'(col_n), 16'(ec));
    check("key_valid", 16'(key_valid), 16'(e_valid));
    check("key_release", 16'(key_release), 16'(e_release));
    check("key_held", 16'(key_held), 16'(accepted));
    check("key_code", 16'(key_code), 16'(e_code));
    if (key_valid) valid_cnt++;
    if (key_release) release_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

  task automatic clks(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int v0, r0;
    clks(3);
    check("rst_col_n", 16'(col_n), 16'hE);
    rst_n = 1'b1;
    clks(40);

    // Single key 6: accept then release.
    v0 = valid_cnt; r0 = release_cnt;
    pressed = 16'h0040;
    clks(4 * SCAN + 2);
    check("t2_valid_cnt", 16'(valid_cnt - v0), 16'd1);
    check("t2_code", 16'(key_code), 16'd6);
    check("t2_held", 16'(key_held), 16'd1);
    pressed = 16'h0000;
    clks(70);
    check("t2_release_cnt", 16'(release_cnt - r0), 16'd1);
    check("t2_held_off", 16'(key_held), 16'd0);
    check("t2_code_kept", 16'(key_code), 16'd6);

    // Bouncing key 6 then stable.
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) begin
      pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      clks(10);
    end
    pressed = 16'h0040;
    clks(90);
    check("t3_valid_cnt", 16'(valid_cnt - v0), 16'd1);
    pressed = 16'h0000;
    clks(70);

    // Keys 6 and 9 together; 9 comes and goes while 6 stays.
    v0 = valid_cnt; r0 = release_cnt;
    pressed = 16'h0240;
    clks(80);
    check("t4_code", 16'(key_code), 16'd6);
    pressed = 16'h0040; clks(40);
    pressed = 16'h0240; clks(40);
    pressed = 16'h0040; clks(40);
    check("t4_valid_cnt", 16'(valid_cnt - v0), 16'd1);
    check("t4_release_cnt", 16'(release_cnt - r0), 16'd0);
    pressed = 16'h0000;
    clks(70);

    // Key roll 3 -> 12.
    v0 = valid_cnt; r0 = release_cnt;
    pressed = 16'h0008;
    clks(80);
    check("t5_code3", 16'(key_code), 16'd3);
    pressed = 16'h1000;
    clks(160);
    check("t5_release_cnt", 16'(release_cnt - r0), 16'd1);
    check("t5_valid_cnt", 16'(valid_cnt - v0), 16'd2);
    check("t5_code12", 16'(key_code), 16'd12);
    pressed = 16'h0000;
    clks(70);

    // Reset while a press is pending; key stays down through reset.
    pressed = 16'h0040;
    clks(SCAN + 10);
    v0 = valid_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_col_rst", 16'(col_n), 16'hE);
    check("t6_valid_rst", 16'(key_valid), 16'd0);
    clks(5);
    rst_n = 1'b1;
    clks(3 * SCAN + 4);
    check("t6_valid_cnt", 16'(valid_cnt - v0), 16'd1);
    check("t6_code", 16'(key_code), 16'd6);
    pressed = 16'h0000;
    clks(70);

    // Randomised key sets, hold times and bounce, checked by the model.
    for (int it = 0; it < 30; it++) begin
      logic [15:0] ks;
      ks = 16'h0000;
      repeat ($urandom_range(0, 2)) ks[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) begin
          pressed = ks; clks($urandom_range(2, 12));
          pressed = 16'h0000; clks($urandom_range(2, 12));
        end
      end
      pressed = ks;
      clks($urandom_range(8, 140));
    end
    pressed = 16'h0000;
    clks(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
